// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// checksum width and the per-state decode of the loader's control outputs.
package imem_loader_pkg;

    localparam int CSUM_WIDTH = 8;
    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHK   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    typedef struct packed {
        logic byte_ready;
        logic mem_we;
        logic cpu_rst;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    // Control outputs are a pure function of the state being entered.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c            = '0;
        c.cpu_rst    = (s != S_DONE);
        c.byte_ready = (s == S_RECV) || (s == S_CHK);
        c.mem_we     = (s == S_WRITE);
        c.busy       = (s == S_RECV) || (s == S_WRITE) || (s == S_CHK);
        c.done       = (s == S_DONE);
        c.err        = (s == S_ERR);
        return c;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian word assembler: each accepted byte shifts in from the top,
// so the first byte of a word ends up in bits [7:0].
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_last
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int CNT_W     = cnt_width(NUM_BYTES);

    logic [DATA_WIDTH-1:0] r_word;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = (r_word >> BYTE_WIDTH)
                     | (DATA_WIDTH'(i_byte) << (DATA_WIDTH - BYTE_WIDTH));
    assign o_last    = (r_cnt == CNT_W'(NUM_BYTES - 1));
    assign o_word    = r_word;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_word <= w_shifted;
            r_cnt  <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a byte stream, writes little-endian words to
// instruction memory, verifies a trailing checksum and releases the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  byte_valid,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t                r_state;
    ctrl_t                 r_ctrl;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [CSUM_WIDTH-1:0] r_csum;

    logic                  w_take;
    logic                  w_idle_like;
    logic                  w_clear;
    logic                  w_shift;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_word;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [CSUM_WIDTH-1:0] w_csum_next;

    assign w_take      = byte_valid && r_ctrl.byte_ready;
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_clear     = w_idle_like && start;
    assign w_shift     = w_take && (r_state == S_RECV);
    assign w_addr_next = r_addr + 1'b1;
    assign w_csum_next = r_csum + byte_data;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_shift (w_shift),
        .i_byte  (byte_data),
        .o_word  (w_word),
        .o_last  (w_last)
    );

    // Outputs are registered alongside the state so they change only on the
    // same edge that enters the new state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ctrl  <= state_ctrl(S_IDLE);
            r_addr  <= '0;
            r_count <= '0;
            r_csum  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state <= S_RECV;
                        r_ctrl  <= state_ctrl(S_RECV);
                        r_addr  <= '0;
                        r_count <= word_count;
                        r_csum  <= '0;
                    end
                end
                S_RECV: begin
                    if (w_take) begin
                        r_csum <= w_csum_next;
                        if (w_last) begin
                            r_state <= S_WRITE;
                            r_ctrl  <= state_ctrl(S_WRITE);
                        end
                    end
                end
                S_WRITE: begin
                    // A latched count of 0 matches only once the address wraps,
                    // which yields the full 2^ADDR_WIDTH words.
                    r_addr <= w_addr_next;
                    if (w_addr_next == r_count) begin
                        r_state <= S_CHK;
                        r_ctrl  <= state_ctrl(S_CHK);
                    end else begin
                        r_state <= S_RECV;
                        r_ctrl  <= state_ctrl(S_RECV);
                    end
                end
                S_CHK: begin
                    if (w_take) begin
                        r_csum <= w_csum_next;
                        if (w_csum_next == '0) begin
                            r_state <= S_DONE;
                            r_ctrl  <= state_ctrl(S_DONE);
                        end else begin
                            r_state <= S_ERR;
                            r_ctrl  <= state_ctrl(S_ERR);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ctrl  <= state_ctrl(S_IDLE);
                end
            endcase
        end
    end

    assign byte_ready = r_ctrl.byte_ready;
    assign mem_we     = r_ctrl.mem_we;
    assign cpu_rst    = r_ctrl.cpu_rst;
    assign busy       = r_ctrl.busy;
    assign done       = r_ctrl.done;
    assign err        = r_ctrl.err;
    assign mem_addr   = r_addr;
    assign mem_wdata  = w_word;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random byte streams are scored against
// a word/checksum model computed directly from the loading rules.
module tb_imem_loader;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] word_count = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [AW+DW-1:0] obs_q[$];
    int               obs_cyc[$];

    imem_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_q.push_back({mem_addr, mem_wdata});
            obs_cyc.push_back(cycle);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] word_of(input logic [7:0] q[$], input int w);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v = v + (DW'(q[w*NB+k]) << (8*k));
        return v;
    endfunction

    function automatic logic [7:0] sum_of(input logic [7:0] q[$]);
        int s;
        s = 0;
        foreach (q[i]) s = s + int'(q[i]);
        return 8'(s % 256);
    endfunction

    function automatic logic [7:0] good_chk(input logic [7:0] q[$]);
        return 8'((256 - int'(sum_of(q))) % 256);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic [AW-1:0] n);
        @(negedge clk);
        start = 1'b1;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 64; t++) begin
            if (byte_ready === 1'b1) begin
                @(negedge clk);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL handshake_timeout: byte %02h not accepted, byte_ready=%b after 64 cycles", b, byte_ready);
    endtask

    task automatic send_all(input logic [7:0] q[$], input logic [7:0] chk, input int max_gap);
        foreach (q[i]) send_byte(q[i], max_gap);
        send_byte(chk, max_gap);
    endtask

    function automatic void rand_bytes(output logic [7:0] q[$], input int n);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({byte_ready, mem_we, cpu_rst, busy, done, err} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_ctrl: {rdy,we,cpu_rst,busy,done,err}=%b expected 001000",
                     {byte_ready, mem_we, cpu_rst, busy, done, err});
        end
        checks++;
        if (mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 0", mem_addr);
        end
        checks++;
        if (mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load(input string name, input logic [7:0] chk);
        logic [7:0]       q[$];
        logic [AW+DW-1:0] exp;
        logic             exp_ok;
        q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_ok = (8'(sum_of(q) + chk) == 8'h00);
        obs_q.delete();
        obs_cyc.delete();
        do_start(AW'(2));
        send_all(q, chk, 0);
        checks++;
        if (obs_q.size() != 2) begin
            failures++;
            $display("FAIL %s_write_count: got %0d expected 2", name, obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            exp = {AW'(i), word_of(q, i)};
            checks++;
            if (obs_q[i] !== exp) begin
                failures++;
                $display("FAIL %s_write%0d: got %h expected %h", name, i, obs_q[i], exp);
            end
        end
        if (obs_cyc.size() == 2) begin
            checks++;
            if (obs_cyc[1] - obs_cyc[0] != 5) begin
                failures++;
                $display("FAIL %s_throughput: write spacing %0d cycles expected 5", name, obs_cyc[1] - obs_cyc[0]);
            end
        end
        checks++;
        if ({done, err, cpu_rst, busy} !== {exp_ok, !exp_ok, !exp_ok, 1'b0}) begin
            failures++;
            $display("FAIL %s_status: {done,err,cpu_rst,busy}=%b expected %b", name,
                     {done, err, cpu_rst, busy}, {exp_ok, !exp_ok, !exp_ok, 1'b0});
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0]       q[$];
        logic [AW+DW-1:0] exp;
        rand_bytes(q, 2*NB);
        obs_q.delete();
        do_start(AW'(2));
        for (int i = 0; i < 2*NB; i++) begin
            if (i == 2) begin
                start = 1'b1;
                word_count = AW'(1);
            end
            if (i == 6) start = 1'b0;
            send_byte(q[i], 0);
        end
        start = 1'b0;
        send_byte(good_chk(q), 0);
        checks++;
        if (obs_q.size() != 2) begin
            failures++;
            $display("FAIL start_ignored_count: got %0d expected 2", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            exp = {AW'(i), word_of(q, i)};
            checks++;
            if (obs_q[i] !== exp) begin
                failures++;
                $display("FAIL start_ignored_write%0d: got %h expected %h", i, obs_q[i], exp);
            end
        end
        checks++;
        if ({done, err} !== 2'b10) begin
            failures++;
            $display("FAIL start_ignored_status: {done,err}=%b expected 10", {done, err});
        end
    endtask

    task automatic test_random_stall();
        logic [7:0]       q[$];
        logic [AW+DW-1:0] exp;
        rand_bytes(q, 3*NB);
        obs_q.delete();
        do_start(AW'(3));
        send_all(q, good_chk(q), 3);
        checks++;
        if (obs_q.size() != 3) begin
            failures++;
            $display("FAIL stall_write_count: got %0d expected 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            exp = {AW'(i), word_of(q, i)};
            checks++;
            if (obs_q[i] !== exp) begin
                failures++;
                $display("FAIL stall_write%0d: got %h expected %h", i, obs_q[i], exp);
            end
        end
        checks++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            failures++;
            $display("FAIL stall_status: {done,err,cpu_rst}=%b expected 100", {done, err, cpu_rst});
        end
    endtask

    task automatic test_wrap();
        logic [7:0]       q[$];
        logic [7:0]       chk;
        logic             exp_ok;
        logic [AW+DW-1:0] exp;
        int               nw;
        nw = 1 << AW;
        rand_bytes(q, nw*NB);
        obs_q.delete();
        do_start('0);
        foreach (q[i]) send_byte(q[i], 0);
        @(negedge clk);
        checks++;
        if ({busy, byte_ready, mem_we, mem_addr} !== {3'b110, AW'(0)}) begin
            failures++;
            $display("FAIL wrap_chk_state: {busy,rdy,we}=%b addr=%h expected 110 addr 0",
                     {busy, byte_ready, mem_we}, mem_addr);
        end
        checks++;
        if (obs_q.size() != nw) begin
            failures++;
            $display("FAIL wrap_write_count: got %0d expected %0d", obs_q.size(), nw);
        end
        for (int i = 0; i < obs_q.size() && i < nw; i++) begin
            exp = {AW'(i), word_of(q, i)};
            checks++;
            if (obs_q[i] !== exp) begin
                failures++;
                $display("FAIL wrap_write%0d: got %h expected %h", i, obs_q[i], exp);
            end
        end
        chk = good_chk(q) + 8'($urandom_range(1, 0));
        exp_ok = (8'(sum_of(q) + chk) == 8'h00);
        send_byte(chk, 0);
        checks++;
        if ({done, err} !== {exp_ok, !exp_ok}) begin
            failures++;
            $display("FAIL wrap_status: {done,err}=%b expected %b", {done, err}, {exp_ok, !exp_ok});
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0]       q[$];
        logic [7:0]       q2[$];
        logic [AW+DW-1:0] exp;
        rand_bytes(q, NB + 2);
        obs_q.delete();
        do_start(AW'(3));
        foreach (q[i]) send_byte(q[i], 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({byte_ready, mem_we, cpu_rst, busy, done, err, mem_addr} !== {6'b001000, AW'(0)}) begin
            failures++;
            $display("FAIL midreset_state: {rdy,we,cpu_rst,busy,done,err}=%b addr=%h expected 001000 addr 0",
                     {byte_ready, mem_we, cpu_rst, busy, done, err}, mem_addr);
        end
        rst = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (obs_q.size() != 1 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL midreset_no_write: writes=%0d busy=%b cpu_rst=%b expected 1/0/1",
                     obs_q.size(), busy, cpu_rst);
        end
        rand_bytes(q2, NB);
        do_start(AW'(1));
        send_all(q2, good_chk(q2), 1);
        exp = {AW'(0), word_of(q2, 0)};
        checks++;
        if (obs_q.size() != 2 || obs_q[obs_q.size()-1] !== exp) begin
            failures++;
            $display("FAIL midreset_reload: writes=%0d last=%h expected 2 writes last %h",
                     obs_q.size(), obs_q[obs_q.size()-1], exp);
        end
        checks++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            failures++;
            $display("FAIL midreset_status: {done,err,cpu_rst}=%b expected 100", {done, err, cpu_rst});
        end
    endtask

    initial begin
        test_reset();
        test_load("good", 8'hB4);
        test_load("bad_8c", 8'h8C);
        test_load("bad_b5", 8'hB5);
        test_start_ignored();
        test_random_stall();
        test_random_stall();
        test_wrap();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
